// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_AW_DEF     = 5;
  localparam int unsigned TMO_CYCLES_DEF = 256;
  localparam int unsigned CNT_W_DEF      = 32;

  // Register x0 is hard-wired to zero, so a load into it never creates a hazard
  localparam int unsigned X0_IDX = 0;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_t;

  // Per-cycle controls sent to IF/ID, the PC and ID/EX
  typedef struct packed {
    logic stall;
    logic flush;
    logic pc_write;
    logic bubble;
  } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Stage-signal bundle between the pipeline datapath and the hazard sequencer.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);

  logic [REG_AW-1:0] ID_rs1_i;
  logic [REG_AW-1:0] ID_rs2_i;
  logic [REG_AW-1:0] EX_rd_i;
  logic              EX_MemRead_i;
  logic              branch_taken_i;
  logic              mem_req_i;
  logic              mem_ack_i;

  logic              mem_start_o;
  logic              MemStall_o;
  logic              stall_o;
  logic              flush_o;
  logic              PC_write_o;
  logic              ID_EX_bubble_o;
  logic              mem_tmo_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  // Datapath side: supplies stage information, consumes controls
  modport master (
    output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           mem_req_i, mem_ack_i,
    input  mem_start_o, MemStall_o, stall_o, flush_o, PC_write_o,
           ID_EX_bubble_o, mem_tmo_o, stall_cnt_o
  );

  // Sequencer side
  modport slave (
    input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, branch_taken_i,
           mem_req_i, mem_ack_i,
    output mem_start_o, MemStall_o, stall_o, flush_o, PC_write_o,
           ID_EX_bubble_o, mem_tmo_o, stall_cnt_o
  );

endinterface

// File: rtl/mem_stall_fsm.sv
// Freezes the pipeline while a multi-cycle data-memory access is outstanding,
// with a sticky timeout when the memory never acknowledges.
module mem_stall_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mem_req_i,
  input  logic mem_ack_i,
  output logic mem_start_o,
  output logic MemStall_o,
  output logic mem_tmo_o
);

  localparam int unsigned      TMO_W    = $clog2(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  mem_state_t       state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;

  // State, timeout counter and sticky error flag
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= MEM_IDLE;
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  // Next state and stall outputs; the ack cycle is still spent in MEM_BUSY so
  // the same MEM instruction is never restarted, and a stray ack in idle is ignored
  always_comb begin
    state_d     = state_q;
    tmo_cnt_d   = '0;
    tmo_d       = tmo_q;
    mem_start_o = 1'b0;
    MemStall_o  = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (mem_req_i) begin
          mem_start_o = 1'b1;
          MemStall_o  = 1'b1;
          state_d     = MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        MemStall_o = ~mem_ack_i;
        if (mem_ack_i) begin
          state_d = MEM_IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  assign mem_tmo_o = tmo_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use detection, branch flush, memory
// freeze priority and a stall-cycle performance counter.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW     = REG_AW_DEF,
  parameter int unsigned TMO_CYCLES = TMO_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input logic                  clk_i,
  input logic                  rst_i,
  pipeline_hazard_ctrl_if.slave bus
);

  logic             mem_start_c;
  logic             mem_stall_c;
  logic             mem_tmo;
  logic             hz_c;
  hz_ctrl_t         ctrl_c;
  logic [CNT_W-1:0] stall_cnt_q;

  // Memory-access freeze sequencer
  mem_stall_fsm #(
    .TMO_CYCLES (TMO_CYCLES)
  ) u_mem_fsm (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mem_req_i   (bus.mem_req_i),
    .mem_ack_i   (bus.mem_ack_i),
    .mem_start_o (mem_start_c),
    .MemStall_o  (mem_stall_c),
    .mem_tmo_o   (mem_tmo)
  );

  // Load in EX feeding a source of the instruction in ID
  assign hz_c = bus.EX_MemRead_i
             && (bus.EX_rd_i != REG_AW'(X0_IDX))
             && ((bus.EX_rd_i == bus.ID_rs1_i) || (bus.EX_rd_i == bus.ID_rs2_i));

  // Priority: memory freeze, then load-use stall, then branch flush; a branch
  // waiting on a load is re-evaluated once the stall clears
  always_comb begin
    ctrl_c          = '0;
    ctrl_c.pc_write = 1'b1;
    if (mem_stall_c) begin
      ctrl_c.pc_write = 1'b0;
    end else if (hz_c) begin
      ctrl_c.stall    = 1'b1;
      ctrl_c.bubble   = 1'b1;
      ctrl_c.pc_write = 1'b0;
    end else if (bus.branch_taken_i) begin
      ctrl_c.flush = 1'b1;
    end
  end

  // Stall-cycle counter, wraps naturally at its width
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (mem_stall_c || ctrl_c.stall) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.mem_start_o    = mem_start_c;
  assign bus.MemStall_o     = mem_stall_c;
  assign bus.stall_o        = ctrl_c.stall;
  assign bus.flush_o        = ctrl_c.flush;
  assign bus.PC_write_o     = ctrl_c.pc_write;
  assign bus.ID_EX_bubble_o = ctrl_c.bubble;
  assign bus.mem_tmo_o      = mem_tmo;
  assign bus.stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed cases then random traffic
// against a cycle-level behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 8;
  localparam int unsigned TMO = 4;

  typedef struct packed {
    logic          start;
    logic          mstall;
    logic          stall;
    logic          flush;
    logic          pcw;
    logic          bubble;
    logic          tmo;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    exp_t  v;
    string tag;
  } item_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  item_t exp_q[$];

  // Behavioural model state
  bit m_busy;
  int m_wait;
  bit m_tmo;
  int m_cnt;

  pipeline_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .REG_AW     (AW),
    .TMO_CYCLES (TMO),
    .CNT_W      (CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs this cycle from the control rules
  function automatic exp_t model_out(input bit req, input bit ack, input bit mr, input bit br,
                                     input int rd, input int rs1, input int rs2);
    exp_t e;
    bit hz, ms;
    hz = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    ms = m_busy ? !ack : req;
    e.start  = !m_busy && req;
    e.mstall = ms;
    e.stall  = hz && !ms;
    e.bubble = hz && !ms;
    e.flush  = br && !hz && !ms;
    e.pcw    = !hz && !ms;
    e.tmo    = m_tmo;
    e.cnt    = CW'(m_cnt);
    return e;
  endfunction

  task automatic drive(input bit req, input bit ack, input bit mr, input bit br,
                       input int rd, input int rs1, input int rs2, input string tag);
    item_t it;
    bus.mem_req_i      = req;
    bus.mem_ack_i      = ack;
    bus.EX_MemRead_i   = mr;
    bus.branch_taken_i = br;
    bus.EX_rd_i        = AW'(rd);
    bus.ID_rs1_i       = AW'(rs1);
    bus.ID_rs2_i       = AW'(rs2);
    it.v   = model_out(req, ack, mr, br, rd, rs1, rs2);
    it.tag = tag;
    exp_q.push_back(it);
    @(posedge clk);
    if (it.v.mstall || it.v.stall) m_cnt = (m_cnt + 1) % (1 << CW);
    if (!m_busy) begin
      if (req) begin
        m_busy = 1'b1;
        m_wait = 0;
      end
    end else begin
      m_wait++;
      if (ack) m_busy = 1'b0;
      else if (m_wait == TMO) begin
        m_tmo  = 1'b1;
        m_busy = 1'b0;
      end
    end
    #1;
  endtask

  // Reset asserted mid-cycle; checked at the following falling edge
  task automatic do_reset(input string tag);
    item_t it;
    rst_n              = 1'b0;
    bus.mem_req_i      = 1'b0;
    bus.mem_ack_i      = 1'b0;
    bus.EX_MemRead_i   = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.EX_rd_i        = '0;
    bus.ID_rs1_i       = '0;
    bus.ID_rs2_i       = '0;
    m_busy = 1'b0;
    m_wait = 0;
    m_tmo  = 1'b0;
    m_cnt  = 0;
    it.v   = model_out(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    it.tag = tag;
    exp_q.push_back(it);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare every presented output against the scoreboard head
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      exp_t  act;
      it  = exp_q.pop_front();
      act = {bus.mem_start_o, bus.MemStall_o, bus.stall_o, bus.flush_o, bus.PC_write_o,
             bus.ID_EX_bubble_o, bus.mem_tmo_o, bus.stall_cnt_o};
      checks++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got start/mstall/stall/flush/pcw/bubble/tmo=%b cnt=%0d, expected %b cnt=%0d",
                 it.tag, act[CW+6:CW], act.cnt, it.v[CW+6:CW], it.v.cnt);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, queue=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Load-use on rs2, then the bubble has moved on
    drive(0, 0, 1, 0, 5, 3, 5, "load_use_rs2");
    drive(0, 0, 0, 0, 0, 3, 5, "load_use_done");
    drive(0, 0, 1, 0, 7, 7, 2, "load_use_rs1");
    // Load into x0 never stalls
    drive(0, 0, 1, 0, 0, 0, 9, "x0_load");
    // Branch flush, and branch held off by load-use
    drive(0, 0, 0, 1, 0, 1, 2, "branch_flush");
    drive(0, 0, 1, 1, 5, 5, 1, "branch_vs_load_use");
    drive(0, 0, 0, 1, 5, 5, 1, "branch_after_stall");
    // Memory access, ack three cycles after start
    drive(1, 0, 0, 0, 0, 0, 0, "mem_start");
    drive(1, 0, 0, 0, 0, 0, 0, "mem_busy1");
    drive(1, 0, 0, 0, 0, 0, 0, "mem_busy2");
    drive(1, 1, 0, 0, 0, 0, 0, "mem_ack");
    drive(0, 0, 0, 0, 0, 0, 0, "mem_after");
    // Memory freeze overlapping branch and load-use
    drive(1, 0, 1, 1, 4, 4, 0, "ovl_start");
    drive(1, 0, 1, 1, 4, 4, 0, "ovl_busy");
    drive(1, 1, 1, 1, 4, 4, 0, "ovl_ack");
    drive(0, 0, 0, 0, 0, 0, 0, "ovl_after");
    // Stray ack while idle
    drive(0, 1, 0, 0, 0, 0, 0, "idle_ack");
    // Timeout with no ack
    drive(1, 0, 0, 0, 0, 0, 0, "tmo_start");
    for (int i = 0; i < TMO + 1; i++) drive(0, 0, 0, 0, 0, 0, 0, "tmo_wait");
    drive(0, 0, 0, 1, 0, 0, 0, "tmo_sticky");
    // Reset in the middle of an access, then a late ack
    drive(1, 0, 0, 0, 0, 0, 0, "rst_start");
    drive(1, 0, 0, 0, 0, 0, 0, "rst_busy");
    do_reset("rst_mid_access");
    drive(0, 1, 0, 0, 0, 0, 0, "late_ack");
    // Counter wrap
    for (int i = 0; i < (1 << CW) + 4; i++) drive(0, 0, 1, 0, 1, 1, 0, "cnt_wrap");
    drive(0, 0, 0, 0, 0, 0, 0, "cnt_wrap_end");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset("rand_reset");
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), "random");
      end
    end

    // Drain the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
